fpu_result_fifo: RTL

Result capture buffer sitting directly downstream of the `fp_add` and `fp_comp` macros inside the FPU interconnect. It detects completion of either unit on its `done` output and packs the result word plus exception flags into one tagged entry. Entries are stored in a small first-word-fall-through FIFO, so Wishbone software can drain results in completion order without missing back-to-back operations. It also produces a level interrupt while results are pending.

---
 rtl/fpu_result_fifo.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fpu_result_fifo.sv
// rtl/fpu_result_fifo.sv - tagged result capture FIFO for fp_add / fp_comp completions
module fpu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          clr_i,
  input  logic          add_done_i,
  input  logic [31:0]   add_res_i,
  input  logic          add_ov_i,
  input  logic          add_un_i,
  input  logic          add_inv_i,
  input  logic          add_inexact_i,
  input  logic          cmp_done_i,
  input  logic          cmp_eq_i,
  input  logic          cmp_great_i,
  input  logic          cmp_less_i,
  input  logic          cmp_inv_i,
  input  logic          rd_i,
  output logic [31:0]   rd_data_o,
  output logic [3:0]    rd_flags_o,
  output logic          rd_tag_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   count_o,
  output logic          ovf_o,
  output logic          irq_o
);

  // Entry layout: {tag, flags[3:0], data[31:0]}
  localparam int          EW       = 37;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          ovf;
  logic          add_done_q;
  logic          cmp_done_q;
  logic          pend_valid;
  logic [EW-1:0] pend_entry;

  logic          add_ev;
  logic          cmp_ev;
  logic [EW-1:0] add_entry;
  logic [EW-1:0] cmp_entry;
  logic [EW-1:0] wr_entry;
  logic          wr_req;
  logic          wr_acc;
  logic          rd_en;
  logic [EW-1:0] head;

  assign add_ev    = add_done_i & ~add_done_q;
  assign cmp_ev    = cmp_done_i & ~cmp_done_q;
  assign add_entry = {1'b0, add_inexact_i, add_inv_i, add_un_i, add_ov_i, add_res_i};
  assign cmp_entry = {1'b1, 1'b0, cmp_inv_i, 2'b00, 29'b0, cmp_less_i, cmp_great_i, cmp_eq_i};

  assign empty_o = (count == '0);
  assign full_o  = (count == FULL_CNT);
  assign rd_en   = rd_i & ~empty_o;
  // A full FIFO still takes a write when a pop frees the head slot in the same cycle
  assign wr_acc  = wr_req & ~clr_i & (~full_o | rd_en);

  // Pick the entry to write: a deferred comp entry drains first, add wins a same-cycle tie
  always_comb begin
    wr_req   = 1'b0;
    wr_entry = '0;
    if (pend_valid) begin
      wr_req   = 1'b1;
      wr_entry = pend_entry;
    end else if (add_ev) begin
      wr_req   = 1'b1;
      wr_entry = add_entry;
    end else if (cmp_ev) begin
      wr_req   = 1'b1;
      wr_entry = cmp_entry;
    end
  end

  // Edge detectors keep tracking through a flush so a held done does not re-capture
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      add_done_q <= 1'b0;
      cmp_done_q <= 1'b0;
    end else begin
      add_done_q <= add_done_i;
      cmp_done_q <= cmp_done_i;
    end
  end

  // Pointers, occupancy, pending comp slot and sticky overflow
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      pend_valid <= 1'b0;
      pend_entry <= '0;
    end else if (clr_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      pend_valid <= 1'b0;
      pend_entry <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)  rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc && !rd_en)      count <= count + ONE_CNT;
      else if (!wr_acc && rd_en) count <= count - ONE_CNT;
      if (wr_req && !wr_acc) ovf <= 1'b1;
      pend_valid <= add_ev & cmp_ev;
      if (add_ev && cmp_ev) pend_entry <= cmp_entry;
    end
  end

  // Entry storage
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_acc) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  assign head       = empty_o ? '0 : mem[rd_ptr];
  assign rd_data_o  = head[31:0];
  assign rd_flags_o = head[35:32];
  assign rd_tag_o   = head[36];
  assign count_o    = count;
  assign ovf_o      = ovf;
  assign irq_o      = ~empty_o;

endmodule
